input_v_access_scheduler: RTL

// - Sequences the shared wind-speed input RAM (N_WT words, one per turbine) between two requesters:
//   the meter write burst (sta_wr) and the exchange read burst (sta_rd).
// - Generates RAM addresses and enables, read-valid strobes with a matching turbine index, and done pulses.
// - Sits between the system timing logic and the input-V RAM. Feeds the parallel V register bank.

---
 rtl/input_v_access_scheduler_if.sv | 44 ++++
 rtl/input_v_access_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/input_v_access_scheduler_if.sv
// Request/RAM-side bundle of the input-V access scheduler.
// Optional overrun ports appear only when INPUT_V_OVERRUN_CHK_EN is defined.
interface input_v_access_scheduler_if #(
   parameter int ADDR_W = 6
);
   logic              sta_wr;
   logic              sta_rd;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic              mem_ena;
   logic              rd_vld;
   logic [ADDR_W-1:0] rd_idx;
   logic              busy;
   logic              done_wr;
   logic              done_rd;
`ifdef INPUT_V_OVERRUN_CHK_EN
   logic              ovr_err;
   logic [7:0]        ovr_cnt;

   modport master (
      output sta_wr, sta_rd,
      input  wr_addr, wr_en, rd_addr, rd_en, mem_ena, rd_vld, rd_idx,
             busy, done_wr, done_rd, ovr_err, ovr_cnt
   );
   modport slave (
      input  sta_wr, sta_rd,
      output wr_addr, wr_en, rd_addr, rd_en, mem_ena, rd_vld, rd_idx,
             busy, done_wr, done_rd, ovr_err, ovr_cnt
   );
`else
   modport master (
      output sta_wr, sta_rd,
      input  wr_addr, wr_en, rd_addr, rd_en, mem_ena, rd_vld, rd_idx,
             busy, done_wr, done_rd
   );
   modport slave (
      input  sta_wr, sta_rd,
      output wr_addr, wr_en, rd_addr, rd_en, mem_ena, rd_vld, rd_idx,
             busy, done_wr, done_rd
   );
`endif
endinterface

// File: rtl/input_v_access_scheduler.sv
// Input-V RAM access scheduler: arbitrates the meter write burst and the
// exchange read burst on one RAM, one beat every STEP clocks, N_WT beats.
// Optional feature macro: INPUT_V_OVERRUN_CHK_EN (sticky overrun flag and
// saturating counter of dropped same-type requests).
module input_v_access_scheduler #(
   parameter int ADDR_W   = 6,
   parameter int N_WT     = 64,
   parameter int STEP     = 8,
   parameter int RD_LAT   = 2,
   parameter int INI_ADDR = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input_v_access_scheduler_if.slave     bus
);
   localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;
   localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(N_WT - 1);
   localparam logic [ADDR_W-1:0] INI      = ADDR_W'(INI_ADDR);
   localparam logic [STEP_W-1:0] STEP_M1  = STEP_W'(STEP - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t                     state;
   logic                       wr_en_r, rd_en_r, done_wr_r, done_rd_r;
   logic [ADDR_W-1:0]          wr_addr_r, rd_addr_r;
   logic [ADDR_W-1:0]          beat_cnt;
   logic [STEP_W-1:0]          step_cnt;
   logic                       pend_wr, pend_rd;
   logic [RD_LAT:1]            vld_pipe;
   logic [RD_LAT:1][ADDR_W-1:0] idx_pipe;

   logic last_beat, step_hit, last_vld;
   assign last_beat = (beat_cnt == LAST_BEAT);
   assign step_hit  = (step_cnt == STEP_M1);
   // idx_pipe carries zero when not valid, so the index compare alone is not enough
   assign last_vld  = vld_pipe[RD_LAT] && (idx_pipe[RD_LAT] == LAST_BEAT);

   // Burst sequencer: beat timing, addresses, pending merges and done pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wr_en_r   <= 1'b0;
         rd_en_r   <= 1'b0;
         done_wr_r <= 1'b0;
         done_rd_r <= 1'b0;
         wr_addr_r <= '0;
         rd_addr_r <= '0;
         beat_cnt  <= '0;
         step_cnt  <= '0;
         pend_wr   <= 1'b0;
         pend_rd   <= 1'b0;
      end else begin
         wr_en_r   <= 1'b0;
         rd_en_r   <= 1'b0;
         done_wr_r <= 1'b0;
         done_rd_r <= 1'b0;
         case (state)
            IDLE: begin
               // write wins a same-clk collision; the read waits as pending
               if (bus.sta_wr || pend_wr) begin
                  state     <= WRITE;
                  wr_en_r   <= 1'b1;
                  wr_addr_r <= INI;
                  beat_cnt  <= '0;
                  step_cnt  <= '0;
                  pend_wr   <= 1'b0;
                  if (bus.sta_rd) pend_rd <= 1'b1;
               end else if (bus.sta_rd || pend_rd) begin
                  state     <= READ;
                  rd_en_r   <= 1'b1;
                  rd_addr_r <= INI;
                  beat_cnt  <= '0;
                  step_cnt  <= '0;
                  pend_rd   <= 1'b0;
               end
            end
            WRITE: begin
               if (bus.sta_rd) pend_rd <= 1'b1;
               if (done_wr_r) begin
                  // a read arriving in the done clk is taken straight away
                  if (pend_rd || bus.sta_rd) begin
                     state     <= READ;
                     rd_en_r   <= 1'b1;
                     rd_addr_r <= INI;
                     beat_cnt  <= '0;
                     step_cnt  <= '0;
                     pend_rd   <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (wr_en_r && last_beat) begin
                  done_wr_r <= 1'b1;
               end else if (step_hit) begin
                  wr_en_r   <= 1'b1;
                  wr_addr_r <= wr_addr_r + ADDR_W'(1);
                  beat_cnt  <= beat_cnt + ADDR_W'(1);
                  step_cnt  <= '0;
               end else begin
                  step_cnt <= step_cnt + STEP_W'(1);
               end
            end
            READ: begin
               if (bus.sta_wr) pend_wr <= 1'b1;
               if (rd_en_r && last_beat) begin
                  state <= DRAIN;
               end else if (step_hit) begin
                  rd_en_r   <= 1'b1;
                  rd_addr_r <= rd_addr_r + ADDR_W'(1);
                  beat_cnt  <= beat_cnt + ADDR_W'(1);
                  step_cnt  <= '0;
               end else begin
                  step_cnt <= step_cnt + STEP_W'(1);
               end
            end
            DRAIN: begin
               if (bus.sta_wr) pend_wr <= 1'b1;
               if (done_rd_r) begin
                  if (pend_wr || bus.sta_wr) begin
                     state     <= WRITE;
                     wr_en_r   <= 1'b1;
                     wr_addr_r <= INI;
                     beat_cnt  <= '0;
                     step_cnt  <= '0;
                     pend_wr   <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (last_vld) begin
                  done_rd_r <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-latency pipe: q-valid strobe and beat index follow rd_en by RD_LAT clks
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         idx_pipe <= '0;
      end else begin
         vld_pipe[1] <= rd_en_r;
         idx_pipe[1] <= rd_en_r ? beat_cnt : '0;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
         end
      end
   end

`ifdef INPUT_V_OVERRUN_CHK_EN
   logic       drop;
   logic       ovr_err_r;
   logic [7:0] ovr_cnt_r;
   assign drop = ((state == WRITE) && bus.sta_wr) ||
                 (((state == READ) || (state == DRAIN)) && bus.sta_rd);

   // Overrun record: sticky flag and saturating count of dropped requests
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovr_err_r <= 1'b0;
         ovr_cnt_r <= '0;
      end else if (drop) begin
         ovr_err_r <= 1'b1;
         if (ovr_cnt_r != 8'hFF) ovr_cnt_r <= ovr_cnt_r + 8'd1;
      end
   end
   assign bus.ovr_err = ovr_err_r;
   assign bus.ovr_cnt = ovr_cnt_r;
`endif

   // In-flight covers every clk from rd_en up to and including its rd_vld
   assign bus.wr_en   = wr_en_r;
   assign bus.wr_addr = wr_addr_r;
   assign bus.rd_en   = rd_en_r;
   assign bus.rd_addr = rd_addr_r;
   assign bus.mem_ena = wr_en_r | rd_en_r | (|vld_pipe);
   assign bus.rd_vld  = vld_pipe[RD_LAT];
   assign bus.rd_idx  = idx_pipe[RD_LAT];
   assign bus.busy    = (state != IDLE);
   assign bus.done_wr = done_wr_r;
   assign bus.done_rd = done_rd_r;
endmodule
